// File: rtl/uart_rx_oversample.sv
// UART receiver, 8N1, LSB first, with a 2-flop input synchronizer and a
// 3-sample majority filter. Start bit is confirmed at mid-bit; data and stop
// bits are sampled one bit period apart from there.
`timescale 1ns/1ps
module uart_rx_oversample #(
  parameter int unsigned BAUD = 868  // clk cycles per serial bit, 8..65535
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic       flag,
  output logic [7:0] data,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(BAUD / 2 - 1);
  localparam logic [15:0] FULL_LAST = 16'(BAUD - 1);

  logic       rxd_meta;
  logic       rxd_s;
  logic [2:0] hist;
  logic       sample;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bi, bi_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  data_n;
  logic        flag_n, err_n;

  // Synchronize the line and keep a short history for the majority vote.
  // Everything resets to the idle (high) line level so a reset never looks
  // like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      hist     <= 3'b111;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      hist     <= {hist[1:0], rxd_s};
    end
  end

  // Majority of the three most recent synchronized samples; a single-cycle
  // glitch can never outvote the other two.
  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bi        <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      flag      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bi        <= bi_n;
      shreg     <= shreg_n;
      data      <= data_n;
      flag      <= flag_n;
      frame_err <= err_n;
    end
  end

  // Next-state and datapath logic. cnt is cleared on every transition so it
  // always counts from the start of the current phase and never wraps.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bi_n    = bi;
    shreg_n = shreg;
    data_n  = data;
    flag_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (sample) begin
            state_n = IDLE;  // false start: line went back high before mid-bit
          end else begin
            state_n = DATA;
            bi_n    = '0;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n   = '0;
          shreg_n = {sample, shreg[7:1]};  // LSB arrives first
          bi_n    = bi + 3'd1;
          if (bi == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack before the next
        // start bit, so back-to-back frames are never missed.
        if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (sample) begin
            data_n  = shreg;
            flag_n  = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not mistaken for a start bit.
        if (rxd_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample at BAUD=16: a table of single frames
// followed by hand-written false-start, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  localparam int BAUD    = 16;
  localparam int LATENCY = 3 + BAUD / 2 + 9 * BAUD;  // 155
  localparam int FRAME   = 10 * BAUD;                // 160

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd = 1'b1;
  logic       flag;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  uart_rx_oversample #(.BAUD(BAUD)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .flag      (flag),
    .data      (data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Rising-edge counter: after edge n, cyc == n.
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Pulse monitor, sampled on the falling edge.
  int          flag_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          long_cnt = 0;
  logic        flag_q = 1'b0;
  logic        err_q = 1'b0;
  int unsigned flag_cyc[$];
  logic [7:0]  flag_data[$];

  always @(negedge clk) begin
    if (flag) begin
      flag_cnt++;
      flag_cyc.push_back(cyc);
      flag_data.push_back(data);
    end
    if (frame_err) err_cnt++;
    if (flag && frame_err) both_cnt++;
    if ((flag && flag_q) || (frame_err && err_q)) long_cnt++;
    flag_q = flag;
    err_q  = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, actual, actual, expected, expected);
    end
  endtask

  int unsigned frame_start = 0;

  // Drive start + 8 data bits + stop bit; rxd is left at the stop level.
  // With glitch set, each data bit is inverted for one cycle at its middle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    frame_start = cyc;
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (glitch) begin
        repeat (BAUD / 2) @(negedge clk);
        rxd = ~b[i];
        @(negedge clk);
        rxd = b[i];
        repeat (BAUD / 2 - 1) @(negedge clk);
      end else begin
        repeat (BAUD) @(negedge clk);
      end
    end
    rxd = stop;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    bit         glitch;
    int         exp_flags;
    int         exp_errs;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int f0, e0, q0;

    vecs[0] = '{tx: 8'hA5, stop: 1'b1, glitch: 1'b0, exp_flags: 1, exp_errs: 0, exp_data: 8'hA5};
    vecs[1] = '{tx: 8'hC3, stop: 1'b1, glitch: 1'b1, exp_flags: 1, exp_errs: 0, exp_data: 8'hC3};
    vecs[2] = '{tx: 8'h3C, stop: 1'b1, glitch: 1'b0, exp_flags: 1, exp_errs: 0, exp_data: 8'h3C};
    vecs[3] = '{tx: 8'h81, stop: 1'b0, glitch: 1'b0, exp_flags: 0, exp_errs: 1, exp_data: 8'h3C};
    vecs[4] = '{tx: 8'h55, stop: 1'b1, glitch: 1'b0, exp_flags: 1, exp_errs: 0, exp_data: 8'h55};
    vecs[5] = '{tx: 8'hE7, stop: 1'b1, glitch: 1'b1, exp_flags: 1, exp_errs: 0, exp_data: 8'hE7};

    // Reset state.
    @(negedge clk);
    check("reset_outputs", {21'd0, flag, frame_err, busy, data}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(10);

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      f0 = flag_cnt;
      e0 = err_cnt;
      send_frame(vecs[v].tx, vecs[v].stop, vecs[v].glitch);
      if (!vecs[v].stop) begin
        // Line held low past the stop bit: receiver must sit in BREAK.
        repeat (40) @(negedge clk);
        check($sformatf("v%0d_busy_in_break", v), busy, 1);
        idle(5);
        check($sformatf("v%0d_busy_after_break", v), busy, 0);
      end
      idle(20);
      check($sformatf("v%0d_flags", v), flag_cnt - f0, vecs[v].exp_flags);
      check($sformatf("v%0d_errs", v), err_cnt - e0, vecs[v].exp_errs);
      check($sformatf("v%0d_data", v), data, vecs[v].exp_data);
      if (vecs[v].exp_flags == 1 && flag_cnt > f0)
        check($sformatf("v%0d_latency", v), flag_cyc[flag_cyc.size() - 1] - frame_start, LATENCY);
    end

    // False start: 3-cycle low pulse.
    f0 = flag_cnt;
    e0 = err_cnt;
    frame_start = cyc;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    check("false_start_busy_high", busy, 1);
    repeat (9) @(negedge clk);
    check("false_start_busy_low", busy, 0);
    idle(30);
    check("false_start_flags", flag_cnt - f0, 0);
    check("false_start_errs", err_cnt - e0, 0);

    // Back-to-back frames with 1-bit stops.
    q0 = flag_cyc.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("b2b_flags", flag_cyc.size() - q0, 3);
    if (flag_cyc.size() >= q0 + 3) begin
      check("b2b_gap1", flag_cyc[q0 + 1] - flag_cyc[q0], FRAME);
      check("b2b_gap2", flag_cyc[q0 + 2] - flag_cyc[q0 + 1], FRAME);
      check("b2b_data0", flag_data[q0], 8'h00);
      check("b2b_data1", flag_data[q0 + 1], 8'hFF);
      check("b2b_data2", flag_data[q0 + 2], 8'h5A);
    end

    // Reset during bit 4 of 0xF0 (bits 4..7 and stop are high, so the
    // remainder of the aborted frame is plain idle line).
    f0 = flag_cnt;
    e0 = err_cnt;
    rxd = 1'b0;
    repeat (5 * BAUD) @(negedge clk);   // start bit + bits 0..3
    rxd = 1'b1;
    repeat (BAUD / 2) @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("midreset_outputs_%0d", i), {21'd0, flag, frame_err, busy, data}, 32'd0);
    end
    rstn = 1'b1;
    idle(3 + 3 * BAUD + BAUD);          // rest of the aborted frame
    idle(20);
    check("midreset_no_flag", flag_cnt - f0, 0);
    check("midreset_no_err", err_cnt - e0, 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20);
    check("after_reset_flags", flag_cnt - f0, 1);
    check("after_reset_data", data, 8'h7E);

    // Pulse-shape invariants collected by the monitor.
    check("flag_and_err_together", both_cnt, 0);
    check("pulse_longer_than_1", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter BAUD, default 868, meaning clk cycles per serial bit; legal range is 8 to 65535.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port rxd, input, 1 bit: asynchronous serial line; idle high; format 8N1, LSB first.
REQ-005 Port flag, output, 1 bit: one-cycle pulse meaning data holds a newly received valid byte.
REQ-006 Port data, output, 8 bits: last valid received byte, held until the next valid byte.
REQ-007 Port frame_err, output, 1 bit: one-cycle pulse meaning the stop bit sampled low; the byte is discarded.
REQ-008 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 rxd SHALL pass through a 2-flop synchronizer; all logic uses only the second flop output, rxd_s.
REQ-010 A 3-entry shift history of rxd_s SHALL be kept; "sample" means the majority vote of the 3 most recent rxd_s values.
REQ-011 States SHALL be IDLE, START, DATA, STOP, BREAK; the counter cnt is 16 bits and the bit index bi is 3 bits.
REQ-012 IDLE: when rxd_s==0, go to START with cnt=0.
REQ-013 START: increment cnt; at cnt==BAUD/2-1 (integer division), evaluate sample:
- sample==1: false start; return to IDLE with no pulse.
- sample==0: go to DATA with cnt=0, bi=0.
REQ-014 DATA: increment cnt; at cnt==BAUD-1, shift sample into the MSB of an 8-bit shift register, set cnt=0, and increment bi; after bi==7 has been sampled, go to STOP.
REQ-015 STOP: increment cnt; at cnt==BAUD-1, evaluate sample:
- sample==1: on the next edge, data takes the shift register, flag=1, and the state returns to IDLE.
- sample==0: frame_err=1 for one cycle, data is unchanged, and the state goes to BREAK.
REQ-016 BREAK: remain until rxd_s==1, then go to IDLE; no pulses are issued while in BREAK.
REQ-017 flag and frame_err SHALL be registered and high for exactly one cycle, and SHALL never be high simultaneously.
REQ-018 Latency: counting the first edge that samples rxd=0 as edge 1, flag SHALL be high in the cycle following edge 3+BAUD/2+9*BAUD (edge 155 for BAUD=16).
REQ-019 Back-to-back frames, with a next start bit immediately after a 1-bit stop, SHALL all be received; this is guaranteed because STOP exits at mid-stop-bit.
REQ-020 A single-cycle rxd glitch falling anywhere within a bit SHALL NOT change that bit's sample.
REQ-021 cnt SHALL never wrap; it is cleared on every state transition.
REQ-022 No backpressure exists: the consumer must accept flag in its pulse cycle, and a missed pulse is lost with no overflow indication.

Reset
REQ-023 While rstn==0:
- state=IDLE, cnt=0, bi=0, shift register=0.
- Both synchronizer flops and the 3-entry history = 1.
- data=8'h00, flag=0, frame_err=0, busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no flag or frame_err pulse; after release, the remainder of the aborted frame is treated as a new line condition (a low level starts a new START evaluation).

Verification (BAUD=16)
REQ-025 Drive byte 0xA5, 8N1 -> exactly one flag pulse, at edge 155 per REQ-018; data==8'hA5; frame_err never high.
REQ-026 Drive a 3-cycle low pulse on idle rxd -> START rejects it; no flag; busy returns to 0 within 12 cycles.
REQ-027 Receive 0x3C, then drive byte 0x81 with the stop bit low -> one frame_err pulse; data remains 8'h3C; the state stays in BREAK until rxd goes high, then a following 0x55 is received correctly.
REQ-028 Drive 0x00, 0xFF, 0x5A back-to-back with 1-bit stops -> three flag pulses spaced exactly 160 cycles apart, with data values in order.
REQ-029 Inject a 1-cycle inverted spike at the mid-point of every data bit of 0xC3 -> data==8'hC3.
REQ-030 Assert rstn low during bit 4 of a frame for 5 cycles, release, then send 0x7E after the line has been idle for 20 cycles:
- During reset, all outputs are 0.
- No pulse is issued for the aborted frame.
- 0x7E is then received correctly.
